fsm_learn: RTL and testbench
============================

Name: fsm_learn

Overview:
- Moore-style serial bit-pattern detector.
- Samples one input bit per clock and asserts `detected` while the last RUN_LEN sampled bits are all 1.
- Default RUN_LEN=2, so the block detects the pattern "11".
- Sits on a serial bit stream as a simple framing/marker detector; it has no handshake.

Parameters:
- RUN_LEN, default 2: number of consecutive 1 bits needed to assert `detected`. Legal range is 1..15.
- CNT_W, default 8: width of the detection counter. Used only when the optional feature is enabled.

Ports:
- clk  input  1  rising-edge clock; all state is updated on this edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_bit  input  1  serial data bit, sampled on each rising clk edge.
- detected  output  1  high while the FSM is in the terminal state S_RUN_LEN.
- detect_count  output  CNT_W  number of detection events. Present only when FSM_LEARN_DETECT_COUNT_EN is defined.

Behaviour:
- States are S0..S_RUN_LEN. Sk means "the last k sampled bits were 1". For the default these are S0, S1, S2.
- State register width is clog2(RUN_LEN+1).
- Reset:
  - reset=0 forces the state to S0 immediately, without waiting for clk.
  - `detected` goes to 0 immediately; `detect_count` goes to 0.
  - The FSM stays in S0 for as long as reset=0.
  - Reset asserted mid-sequence discards all partial progress.
- Transitions, evaluated on every rising edge while reset=1:
  - in_bit=0 from any state: go to S0.
  - in_bit=1 in Sk with k<RUN_LEN: go to S(k+1).
  - in_bit=1 in S_RUN_LEN: stay in S_RUN_LEN. Detection is overlapping, so a run of ones keeps `detected` high.
- Output:
  - detected = (state == S_RUN_LEN). It is decoded purely from the state register, so it is glitch-free and independent of in_bit.
  - Latency: `detected` rises in the cycle immediately after the edge that samples the RUN_LEN-th consecutive 1.
  - `detected` falls in the cycle after the edge that samples a 0.
- Reset release:
  - The first edge with reset=1 samples in_bit normally.
  - in_bit values presented while reset=0 are ignored.
- Illegal or unreachable state encodings go to S0 on the next edge, with detected=0.
- RUN_LEN=1 degenerates to: detected = the in_bit value registered on the previous edge.

Optional Feature:
- Macro: FSM_LEARN_DETECT_COUNT_EN.
- Defined:
  - Adds output `detect_count` [CNT_W-1:0].
  - It increments by 1 on each edge where the FSM enters S_RUN_LEN from S(RUN_LEN-1), i.e. once per rising edge of `detected`.
  - Staying in S_RUN_LEN does not increment it.
  - It saturates at all-ones and does not wrap.
  - It is cleared asynchronously by reset=0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package fsm_learn_pkg holds:
  - the state width function (clog2 of RUN_LEN+1);
  - named constants for S0 and for the terminal state;
  - the default for the counter saturation value.
- Sub-modules:
  - One natural sub-module, fsm_learn_sat_counter: saturating CNT_W counter with async active-low clear and an increment strobe. It is instantiated only under the macro.
  - The FSM itself stays in the top module.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles while toggling in_bit.
  - Required: detected=0 throughout; detect_count=0.
  - Stimulus: assert reset=0 between clock edges while in S2.
  - Required: detected drops to 0 before the next edge.
- Sequence "0011011" after reset release:
  - Required: detected is high after the 4th bit.
  - Required: detected is low after the 5th bit (0).
  - Required: detected is high again after the 7th bit.
  - Required: detect_count=2.
- Sequence "11011" after a mid-stream reset:
  - Required: detected is high after bits 2 and 5.
  - Required: detected is low after bit 3.
  - Required: detect_count=2; the count restarted from 0.
- Sequence "1001011":
  - Required: detected stays 0 until the final bit.
  - Required: detected is high after bit 7; detect_count=1.
- Overlap and saturation:
  - Stimulus: hold in_bit=1 for 20 cycles.
  - Required: detected stays high from cycle 2 onward; detect_count=1.
  - Stimulus: with CNT_W=2, apply the pattern "110" repeated 6 times.
  - Required: detect_count saturates at 3.
- Parameter sweep:
  - RUN_LEN=3 with "110111": detected is high only after bit 6.
  - RUN_LEN=1: detected equals in_bit delayed by one cycle.

Source files
------------

// File: rtl/fsm_learn_pkg.sv
// Shared constants and helpers for the fsm_learn run-of-ones detector.
package fsm_learn_pkg;

  localparam int RUN_LEN_DEF = 2;
  localparam int CNT_W_DEF   = 8;

  // State index of the idle state; the terminal state index equals RUN_LEN.
  localparam int S0 = 0;

  // Counter saturation value for the default counter width.
  localparam logic [CNT_W_DEF-1:0] SAT_MAX_DEF = '1;

  function automatic int state_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

  function automatic int s_term(input int run_len);
    return run_len;
  endfunction

endpackage

// File: rtl/fsm_learn_sat_counter.sv
// Saturating event counter with async active-low clear and an increment strobe.
import fsm_learn_pkg::*;

module fsm_learn_sat_counter #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] SAT_MAX = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         count <= '0;
    else if (inc && (count != SAT_MAX)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/fsm_learn.sv
// Moore detector: detected is high while the last RUN_LEN sampled bits were all 1.
// Define FSM_LEARN_DETECT_COUNT_EN to add the saturating detect_count output.
import fsm_learn_pkg::*;

module fsm_learn #(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  output logic             detected
`ifdef FSM_LEARN_DETECT_COUNT_EN
  ,
  output logic [CNT_W-1:0] detect_count
`endif
);

  localparam int SW = state_w(RUN_LEN);
  localparam logic [SW-1:0] ST_IDLE = SW'(S0);
  localparam logic [SW-1:0] ST_TERM = SW'(s_term(RUN_LEN));

  logic [SW-1:0] state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Any 0, and any encoding above the terminal state, falls back to idle.
  always_comb begin
    state_d = ST_IDLE;
    if (in_bit) begin
      if (state_q < ST_TERM)       state_d = state_q + SW'(1);
      else if (state_q == ST_TERM) state_d = ST_TERM;
    end
  end

  always_comb begin
    detected = (state_q == ST_TERM);
  end

`ifdef FSM_LEARN_DETECT_COUNT_EN
  localparam logic [SW-1:0] ST_PRE = ST_TERM - SW'(1);

  logic enter;
  assign enter = (state_q == ST_PRE) && (state_d == ST_TERM);

  fsm_learn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (enter),
    .count (detect_count)
  );
`endif

endmodule

// File: tb/tb_fsm_learn.sv
// Directed bench for fsm_learn: RUN_LEN=2/3/1 instances plus a CNT_W=2 count instance.
module tb_fsm_learn;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_bit = 1'b0;
  logic det2, det3, det1, det2s;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

`ifdef FSM_LEARN_DETECT_COUNT_EN
  logic [7:0] cnt2, cnt3, cnt1;
  logic [1:0] cnt2s;
  fsm_learn #(.RUN_LEN(2), .CNT_W(8)) u2  (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det2),  .detect_count(cnt2));
  fsm_learn #(.RUN_LEN(3), .CNT_W(8)) u3  (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det3),  .detect_count(cnt3));
  fsm_learn #(.RUN_LEN(1), .CNT_W(8)) u1  (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det1),  .detect_count(cnt1));
  fsm_learn #(.RUN_LEN(2), .CNT_W(2)) u2s (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det2s), .detect_count(cnt2s));
`else
  fsm_learn #(.RUN_LEN(2), .CNT_W(8)) u2  (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det2));
  fsm_learn #(.RUN_LEN(3), .CNT_W(8)) u3  (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det3));
  fsm_learn #(.RUN_LEN(1), .CNT_W(8)) u1  (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det1));
  fsm_learn #(.RUN_LEN(2), .CNT_W(2)) u2s (.clk(clk), .reset(reset), .in_bit(in_bit), .detected(det2s));
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive the bit, let one posedge sample it, return at the next negedge.
  task automatic step(input logic b);
    in_bit = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    in_bit = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
  endtask

  task automatic run_seq(input string name, input logic [15:0] bits, input int len,
                         input logic [15:0] exp2, input logic [15:0] exp3, input logic [15:0] exp1);
    // Bit i (MSB first) is bits[len-1-i]; expectations use the same indexing.
    for (int i = 0; i < len; i++) begin
      step(bits[len-1-i]);
      chk($sformatf("%s_r2_b%0d", name, i+1), int'(det2), int'(exp2[len-1-i]));
      chk($sformatf("%s_r3_b%0d", name, i+1), int'(det3), int'(exp3[len-1-i]));
      chk($sformatf("%s_r1_b%0d", name, i+1), int'(det1), int'(exp1[len-1-i]));
    end
  endtask

  initial begin
    @(negedge clk);
    // Held in reset while in_bit toggles.
    for (int i = 0; i < 4; i++) begin
      step(i[0] ? 1'b0 : 1'b1);
      chk($sformatf("rst_hold_det_%0d", i), int'(det2), 0);
      chk($sformatf("rst_hold_det1_%0d", i), int'(det1), 0);
`ifdef FSM_LEARN_DETECT_COUNT_EN
      chk($sformatf("rst_hold_cnt_%0d", i), int'(cnt2), 0);
`endif
    end
    reset = 1'b1;

    // "0011011": RUN_LEN=2 high after bits 4 and 7.
    run_seq("s0011011", 16'b0011011, 7, 16'b0001001, 16'b0000000, 16'b0011011);
`ifdef FSM_LEARN_DETECT_COUNT_EN
    chk("s0011011_cnt", int'(cnt2), 2);
`endif

    // Async reset between edges while in S2.
    chk("pre_async_det", int'(det2), 1);
    #2 reset = 1'b0;
    #1 chk("async_det", int'(det2), 0);
`ifdef FSM_LEARN_DETECT_COUNT_EN
    chk("async_cnt", int'(cnt2), 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // "11011" after mid-stream reset.
    run_seq("s11011", 16'b11011, 5, 16'b01001, 16'b00000, 16'b11011);
`ifdef FSM_LEARN_DETECT_COUNT_EN
    chk("s11011_cnt", int'(cnt2), 2);
`endif

    do_reset();
    run_seq("s1001011", 16'b1001011, 7, 16'b0000001, 16'b0000000, 16'b1001011);
`ifdef FSM_LEARN_DETECT_COUNT_EN
    chk("s1001011_cnt", int'(cnt2), 1);
`endif

    // Long run of ones: overlapping detection, single count.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      chk($sformatf("ones_c%0d", i), int'(det2), (i >= 2) ? 1 : 0);
    end
`ifdef FSM_LEARN_DETECT_COUNT_EN
    chk("ones_cnt", int'(cnt2), 1);
    chk("ones_cnt_w2", int'(cnt2s), 1);
`endif

    // "110" x6 on a 2-bit counter: saturates at 3.
    do_reset();
    for (int r = 1; r <= 6; r++) begin
      step(1'b1);
      step(1'b1);
      chk($sformatf("sat_det_r%0d", r), int'(det2s), 1);
      step(1'b0);
`ifdef FSM_LEARN_DETECT_COUNT_EN
      chk($sformatf("sat_cnt_r%0d", r), int'(cnt2s), (r < 3) ? r : 3);
      chk($sformatf("sat_cnt8_r%0d", r), int'(cnt2), r);
`endif
    end

    // RUN_LEN=3 "110111" high only after bit 6; RUN_LEN=1 follows in_bit by one edge.
    do_reset();
    run_seq("s110111", 16'b110111, 6, 16'b010011, 16'b000001, 16'b110111);

    do_reset();
    run_seq("s10110010", 16'b10110010, 8, 16'b00010000, 16'b00000000, 16'b10110010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
